// File: rtl/timer_counter_ctrl.sv
// Counting controller for the 8-bit timer: aligns to the sampled divided clock,
// turns its rising edges into count ticks and keeps sticky overflow/underflow flags.
module timer_counter_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             int_clk,
    input  logic [1:0]       cks,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] tdr,
    input  logic             cnt_dn,
    input  logic             ovf_clr,
    input  logic             udf_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             tmr_ovf,
    output logic             tmr_udf,
    output logic             running
);

    localparam logic [WIDTH-1:0] MAXV = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             int_clk_q;
    logic [1:0]       cks_q;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             running_q, running_d;

    logic             rise;
    logic             cks_chg;
    logic             tick;

    assign rise    = int_clk & ~int_clk_q;
    assign cks_chg = (cks != cks_q);
    // A tick is lost on disable or clock-select change; the old period is discarded.
    assign tick    = rise & (state_q == RUN) & en & ~cks_chg;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= IDLE;
            int_clk_q <= 1'b0;
            cks_q     <= 2'b00;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            int_clk_q <= int_clk;
            cks_q     <= cks;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            running_q <= running_d;
        end
    end

    // Next-state, counter and flag update
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;

        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ARMED;
                ARMED:   if (rise) state_d = RUN;
                RUN:     if (cks_chg) state_d = ARMED;
                default: state_d = IDLE;
            endcase
        end

        if (ovf_clr) ovf_d = 1'b0;
        if (udf_clr) udf_d = 1'b0;

        // Load beats a coincident tick; a set beats a coincident clear.
        if (load) begin
            cnt_d = tdr;
        end else if (tick) begin
            if (!cnt_dn) begin
                if (cnt_q == MAXV) begin
                    cnt_d = '0;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    cnt_d = MAXV;
                    udf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end

        running_d = (state_d == RUN);
    end

    assign cnt     = cnt_q;
    assign tmr_ovf = ovf_q;
    assign tmr_udf = udf_q;
    assign running = running_q;

endmodule

// File: tb/tb_timer_counter_ctrl.sv
// Directed table-driven bench for timer_counter_ctrl, plus an async-reset sequence.
module tb_timer_counter_ctrl;

    logic       pclk;
    logic       preset_n;
    logic       int_clk;
    logic [1:0] cks;
    logic       en;
    logic       load;
    logic [7:0] tdr;
    logic       cnt_dn;
    logic       ovf_clr;
    logic       udf_clr;
    logic [7:0] cnt;
    logic       tmr_ovf;
    logic       tmr_udf;
    logic       running;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic       en;
        logic [1:0] cks;
        logic       load;
        logic [7:0] tdr;
        logic       dn;
        logic       rise;
        logic       oc;
        logic       uc;
        logic [7:0] e_cnt;
        logic       e_ovf;
        logic       e_udf;
        logic       e_run;
    } vec_t;

    vec_t vecs[$];

    timer_counter_ctrl #(.WIDTH(8)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .int_clk  (int_clk),
        .cks      (cks),
        .en       (en),
        .load     (load),
        .tdr      (tdr),
        .cnt_dn   (cnt_dn),
        .ovf_clr  (ovf_clr),
        .udf_clr  (udf_clr),
        .cnt      (cnt),
        .tmr_ovf  (tmr_ovf),
        .tmr_udf  (tmr_udf),
        .running  (running)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic add(input logic e, input logic [1:0] c, input logic ld, input logic [7:0] d,
                       input logic dn, input logic r, input logic oc, input logic uc,
                       input logic [7:0] ec, input logic eo, input logic eu, input logic er);
        vec_t v;
        v = '{e, c, ld, d, dn, r, oc, uc, ec, eo, eu, er};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got cnt=%h ovf=%b udf=%b run=%b, want cnt=%h ovf=%b udf=%b run=%b",
                      name, act[10:3], act[2], act[1], act[0], exp[10:3], exp[2], exp[1], exp[0]);
    endtask

    initial begin
        //   en cks ld tdr   dn r  oc uc   cnt    ovf udf run
        add(1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0); // IDLE -> ARMED
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 1); // alignment edge
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h01, 0, 0, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h02, 0, 0, 1);
        add(1, 0, 1, 8'hFE, 0, 0, 0, 0, 8'hFE, 0, 0, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'hFF, 0, 0, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 1, 0, 1); // overflow
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h01, 1, 0, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h02, 1, 0, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h03, 1, 0, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h04, 1, 0, 1);
        add(1, 0, 0, 8'h00, 0, 1, 0, 0, 8'h05, 1, 0, 1);
        add(1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h05, 0, 0, 1); // ovf_clr
        add(1, 0, 1, 8'h01, 1, 0, 0, 0, 8'h01, 0, 0, 1);
        add(1, 0, 0, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 1);
        add(1, 0, 0, 8'h00, 1, 1, 0, 0, 8'hFF, 0, 1, 1); // underflow
        add(1, 0, 0, 8'h00, 1, 0, 0, 1, 8'hFF, 0, 0, 1); // udf_clr
        add(1, 0, 1, 8'h40, 0, 1, 0, 0, 8'h40, 0, 0, 1); // load beats tick
        add(1, 0, 1, 8'hFF, 0, 0, 0, 0, 8'hFF, 0, 0, 1);
        add(1, 0, 0, 8'h00, 0, 1, 1, 0, 8'h00, 1, 0, 1); // set beats clear
        add(1, 0, 1, 8'h10, 0, 0, 0, 0, 8'h10, 1, 0, 1);
        add(1, 3, 0, 8'h00, 0, 1, 0, 0, 8'h10, 1, 0, 0); // cks change drops tick
        add(1, 3, 0, 8'h00, 0, 1, 0, 0, 8'h10, 1, 0, 1); // realign
        add(1, 3, 0, 8'h00, 0, 1, 0, 0, 8'h11, 1, 0, 1);
        add(1, 3, 1, 8'h33, 0, 0, 0, 0, 8'h33, 1, 0, 1);
        add(0, 3, 0, 8'h00, 0, 1, 0, 0, 8'h33, 1, 0, 0); // disable suppresses tick
        add(0, 3, 0, 8'h00, 0, 1, 0, 0, 8'h33, 1, 0, 0);
        add(1, 3, 0, 8'h00, 0, 0, 0, 0, 8'h33, 1, 0, 0);
        add(1, 3, 0, 8'h00, 0, 1, 0, 0, 8'h33, 1, 0, 1); // realign after re-enable
        add(1, 3, 0, 8'h00, 0, 1, 0, 0, 8'h34, 1, 0, 1);

        preset_n = 1'b0;
        int_clk  = 1'b0;
        cks      = 2'b00;
        en       = 1'b0;
        load     = 1'b0;
        tdr      = 8'h00;
        cnt_dn   = 1'b0;
        ovf_clr  = 1'b0;
        udf_clr  = 1'b0;
        cyc();
        cyc();
        check("reset", {cnt, tmr_ovf, tmr_udf, running}, {8'h00, 1'b0, 1'b0, 1'b0});
        preset_n = 1'b1;
        cyc();
        check("idle_after_reset", {cnt, tmr_ovf, tmr_udf, running}, {8'h00, 1'b0, 1'b0, 1'b0});

        foreach (vecs[i]) begin
            en      = vecs[i].en;
            cks     = vecs[i].cks;
            load    = vecs[i].load;
            tdr     = vecs[i].tdr;
            cnt_dn  = vecs[i].dn;
            int_clk = vecs[i].rise;
            ovf_clr = vecs[i].oc;
            udf_clr = vecs[i].uc;
            cyc();
            load    = 1'b0;
            ovf_clr = 1'b0;
            udf_clr = 1'b0;
            int_clk = 1'b0;
            cyc();
            check($sformatf("vec%0d", i), {cnt, tmr_ovf, tmr_udf, running},
                  {vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_udf, vecs[i].e_run});
        end

        // Async reset in the middle of a clock period, no edge needed
        int_clk = 1'b1;
        #1;
        preset_n = 1'b0;
        #1;
        check("async_reset", {cnt, tmr_ovf, tmr_udf, running}, {8'h00, 1'b0, 1'b0, 1'b0});
        cyc();
        check("held_in_reset", {cnt, tmr_ovf, tmr_udf, running}, {8'h00, 1'b0, 1'b0, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/timer_counter_ctrl.md
Name: timer_counter_ctrl

Overview:
Counting controller for the 8-bit timer. It runs entirely in the pclk domain and samples int_clk, the divided clock chosen by cks in the clock-select block, as a data signal. The block turns each int_clk rising edge into a one-pclk count tick. It sequences start, reload and count direction, and raises sticky overflow/underflow flags for the register/interrupt logic.

Parameters:
WIDTH, 8, counter width in bits; max count MAXV = 2^WIDTH-1.

Ports:
pclk  input  1  system clock; all state updates on its rising edge.
preset_n  input  1  asynchronous active-low reset.
int_clk  input  1  selected divided clock from the clock-select block; sampled by pclk.
cks  input  2  current clock-select code, the same value that drives the clock-select block.
en  input  1  level; 1 = timer enabled.
load  input  1  one-cycle pulse; load tdr into counter.
tdr  input  WIDTH  reload value.
cnt_dn  input  1  0 = count up, 1 = count down.
ovf_clr  input  1  pulse; clear tmr_ovf.
udf_clr  input  1  pulse; clear tmr_udf.
cnt  output  WIDTH  current count value.
tmr_ovf  output  1  sticky overflow flag.
tmr_udf  output  1  sticky underflow flag.
running  output  1  1 when state = RUN.

Behaviour:
- Reset (preset_n=0, async): cnt=0, tmr_ovf=0, tmr_udf=0, running=0, state=IDLE, int_clk_q=0, cks_q=00.
- Edge detect: int_clk_q <= int_clk every pclk. rise = int_clk & ~int_clk_q. tick = rise & (state==RUN).
- cks_q <= cks every pclk. cks_chg = (cks != cks_q).
- FSM states: IDLE, ARMED, RUN.
  - IDLE -> ARMED when en=1.
  - ARMED -> RUN on the first rise. That edge does not count; it only aligns to the divided clock.
  - RUN -> ARMED on cks_chg, which discards the partial period of the old clock. No tick is taken in that cycle.
  - Any state -> IDLE when en=0. The same cycle suppresses tick; cnt holds its value.
- running = (state==RUN), registered with the state.
- Counter update priority per pclk edge: load > tick > hold.
  - load=1: cnt <= tdr, in any state. A tick in the same cycle is dropped and no flag is set.
  - tick with cnt_dn=0: if cnt==MAXV, cnt <= 0 and tmr_ovf <= 1; else cnt <= cnt+1.
  - tick with cnt_dn=1: if cnt==0, cnt <= MAXV and tmr_udf <= 1; else cnt <= cnt-1.
  - Arithmetic wraps modulo 2^WIDTH.
- Latency: cnt and flags change on the pclk edge where tick=1 and are visible the following cycle.
- Flags are sticky until cleared. If a clear and a set coincide in one cycle, set wins and the flag stays 1. The clear takes effect one cycle after the pulse.
- cnt_dn may change at any time; the new value applies to the next tick.
- en deassert then reassert: the FSM re-enters ARMED and cnt resumes from its held value after one alignment edge.
- Reset asserted mid-count: everything returns to reset values immediately, with no partial update.
- int_clk static (no rising edges): the FSM stays in ARMED or RUN and cnt holds.

Test Plan:
- Reset/arm: with preset_n low, cnt=0 and flags=0. Release reset, en=1, toggle int_clk → running=1 after the 1st rise; cnt=1 after the 2nd rise, 2 after the 3rd.
- Overflow: load tdr=8'hFE, cnt_dn=0, RUN → cnt=FF after 1 tick; next tick gives cnt=00 and tmr_ovf=1. tmr_ovf stays 1 over 5 more ticks. ovf_clr pulse → tmr_ovf=0 the next cycle.
- Underflow: load tdr=8'h01, cnt_dn=1 → after 2 ticks cnt=FF and tmr_udf=1; tmr_ovf stays 0.
- Collisions:
  - load=1 (tdr=8'h40) in the same cycle as tick → cnt=40, not 41.
  - ovf_clr in the same cycle as a new overflow → tmr_ovf remains 1.
- cks change: in RUN with cnt=10, change cks 00→11 → running drops to 0. The first int_clk rise afterwards does not count (cnt=10); the next rise gives cnt=11.
- Disable/async reset: en=0 in RUN with cnt=33 → running=0 and cnt holds 33 despite int_clk edges. Assert preset_n=0 mid-count → cnt=0 and both flags 0 without waiting for a pclk edge.
